// File: rtl/dht_pkg.sv
// dht_pkg: shared definitions for the DHT11/DHT22 single-wire reader.
//   - FSM state type and encodings
//   - ERR_CODE values
//   - fixed protocol durations in microseconds
//   - us_to_cyc(): microseconds to clock cycles on the 24-bit phase counter
package dht_pkg;

    localparam int unsigned PHASE_W = 24;

    typedef logic [3:0] dht_state_t;

    localparam dht_state_t S_IDLE      = 4'd0;
    localparam dht_state_t S_START_LOW = 4'd1;
    localparam dht_state_t S_RELEASE   = 4'd2;
    localparam dht_state_t S_RESP_LOW  = 4'd3;
    localparam dht_state_t S_RESP_HIGH = 4'd4;
    localparam dht_state_t S_BIT_LOW   = 4'd5;
    localparam dht_state_t S_BIT_HIGH  = 4'd6;
    localparam dht_state_t S_CHECK     = 4'd7;
    localparam dht_state_t S_HOLDOFF   = 4'd8;
    localparam dht_state_t S_COOL      = 4'd9;

    localparam logic [2:0] E_OK        = 3'd0;
    localparam logic [2:0] E_NO_RESP   = 3'd1;
    localparam logic [2:0] E_RESP_LOW  = 3'd2;
    localparam logic [2:0] E_RESP_HIGH = 3'd3;
    localparam logic [2:0] E_BIT       = 3'd4;
    localparam logic [2:0] E_CRC       = 3'd5;

    localparam int unsigned START_US_DHT11 = 18000;
    localparam int unsigned START_US_DHT22 = 1000;
    localparam int unsigned HOLDOFF_US     = 2000;
    localparam int unsigned MS_US          = 1000;

    // Depth of the input synchronizer; the line is ignored for this many
    // cycles after release so our own low drive is not mistaken for a response.
    localparam int unsigned SYNC_LAG = 2;

    function automatic logic [PHASE_W-1:0] us_to_cyc(input int unsigned us,
                                                      input int unsigned cyc_us);
        return PHASE_W'(us * cyc_us);
    endfunction

endpackage

// File: rtl/dht_pad.sv
// dht_pad: open-drain pad for the DHT single-wire line.
// Ports:
//   CLK, RST    clock, synchronous active-low reset
//   drive_low   1 = pull the line to 0, 0 = release (Z, external pull-up)
//   DHT_DATA    the open-drain line
//   line_sync   line level after a 2-FF synchronizer
module dht_pad (
    input  logic CLK,
    input  logic RST,
    input  logic drive_low,
    inout  wire  DHT_DATA,
    output logic line_sync
);

    logic meta;

    assign DHT_DATA = drive_low ? 1'b0 : 1'bz;

    // Reset to the idle (pulled-up) level so no false edge follows reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            meta      <= 1'b1;
            line_sync <= 1'b1;
        end else begin
            meta      <= DHT_DATA;
            line_sync <= meta;
        end
    end

endmodule

// File: rtl/dht_reader.sv
// dht_reader: clock-agnostic DHT11/DHT22 reader.
// Generates the host start pulse, checks the sensor response, decodes 40 data
// bits MSB-first, retries failed attempts and reports a coded error.
// Ports:
//   CLK, RST        clock, synchronous active-low reset
//   START           request, sampled only in IDLE
//   MODE            0 = DHT11 (18 ms start), 1 = DHT22 (1 ms start); latched on START
//   DHT_DATA        open-drain sensor line
//   BUSY            high from the cycle after START acceptance until back in IDLE
//   DONE            one-cycle completion pulse (success or final failure)
//   ERR, ERR_CODE   result of the last attempt, valid with DONE, held until next DONE
//   HUM, TEMP, CRC  frame bytes {b0,b1}, {b2,b3}, b4; updated only on success
// Build option: define DHT_CRC_CHECK_EN to verify the checksum byte.
module dht_reader
    import dht_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned RETRIES = 2,
    parameter int unsigned COOL_MS = 1000,
    parameter int unsigned BIT1_US = 50,
    parameter int unsigned TMO_US  = 100
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        MODE,
    inout  wire         DHT_DATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [2:0]  ERR_CODE,
    output logic [15:0] HUM,
    output logic [15:0] TEMP,
    output logic [7:0]  CRC
);

    localparam int unsigned CYC_US = CLK_HZ / 1_000_000;

    localparam logic [PHASE_W-1:0] T11_M1  = us_to_cyc(START_US_DHT11, CYC_US) - 24'd1;
    localparam logic [PHASE_W-1:0] T22_M1  = us_to_cyc(START_US_DHT22, CYC_US) - 24'd1;
    localparam logic [PHASE_W-1:0] HOLD_M1 = us_to_cyc(HOLDOFF_US, CYC_US) - 24'd1;
    localparam logic [PHASE_W-1:0] MS_M1   = us_to_cyc(MS_US, CYC_US) - 24'd1;
    localparam logic [PHASE_W-1:0] TMO_M1  = us_to_cyc(TMO_US, CYC_US) - 24'd1;
    localparam logic [PHASE_W-1:0] TBIT1   = us_to_cyc(BIT1_US, CYC_US);
    localparam logic [PHASE_W-1:0] BLANK   = PHASE_W'(SYNC_LAG);
    localparam logic [15:0]        COOL_M1 = 16'(COOL_MS - 1);
    localparam logic [2:0]         RETRY_MAX = 3'(RETRIES);

    dht_state_t         state, nxt;
    logic [PHASE_W-1:0] cnt;
    logic [15:0]        ms_cnt;
    logic [5:0]         bit_idx;
    logic [39:0]        shreg;
    logic [2:0]         retry;
    logic               mode_q;
    logic               line_sync;
    logic               drive_low;

    logic               fail;
    logic [2:0]         fail_code;
    logic               shift_en;
    logic               bit_val;
    logic               ok_done;
    logic               cool_tick;
    logic               cool_done;
    logic [PHASE_W-1:0] start_m1;

    assign drive_low = (state == S_START_LOW);
    assign start_m1  = mode_q ? T22_M1 : T11_M1;

    // COOL can exceed the 24-bit phase range, so it is counted in
    // milliseconds: the phase counter wraps every ms and ms_cnt tallies them.
    assign cool_tick = (state == S_COOL) && (cnt == MS_M1);
    assign cool_done = cool_tick && (ms_cnt == COOL_M1);

`ifdef DHT_CRC_CHECK_EN
    logic [7:0] crc_sum;
    assign crc_sum = shreg[39:32] + shreg[31:24] + shreg[23:16] + shreg[15:8];
`endif

    dht_pad u_pad (
        .CLK       (CLK),
        .RST       (RST),
        .drive_low (drive_low),
        .DHT_DATA  (DHT_DATA),
        .line_sync (line_sync)
    );

    always_comb begin
        nxt       = state;
        fail      = 1'b0;
        fail_code = E_OK;
        shift_en  = 1'b0;
        bit_val   = 1'b0;
        ok_done   = 1'b0;
        case (state)
            S_IDLE: begin
                if (START) nxt = S_START_LOW;
            end
            S_START_LOW: begin
                if (cnt == start_m1) nxt = S_RELEASE;
            end
            S_RELEASE: begin
                if (cnt >= BLANK && !line_sync) begin
                    nxt = S_RESP_LOW;
                end else if (cnt >= TMO_M1) begin
                    fail      = 1'b1;
                    fail_code = E_NO_RESP;
                end
            end
            S_RESP_LOW: begin
                if (line_sync) begin
                    nxt = S_RESP_HIGH;
                end else if (cnt >= TMO_M1) begin
                    fail      = 1'b1;
                    fail_code = E_RESP_LOW;
                end
            end
            S_RESP_HIGH: begin
                if (!line_sync) begin
                    nxt = S_BIT_LOW;
                end else if (cnt >= TMO_M1) begin
                    fail      = 1'b1;
                    fail_code = E_RESP_HIGH;
                end
            end
            S_BIT_LOW: begin
                if (line_sync) begin
                    nxt = S_BIT_HIGH;
                end else if (cnt >= TMO_M1) begin
                    fail      = 1'b1;
                    fail_code = E_BIT;
                end
            end
            S_BIT_HIGH: begin
                if (!line_sync) begin
                    // High time is cnt+1 cycles; "cnt+1 > TBIT1" is written
                    // as "cnt >= TBIT1" so a saturated counter cannot wrap.
                    shift_en = 1'b1;
                    bit_val  = (cnt >= TBIT1);
                    nxt      = (bit_idx == 6'd39) ? S_CHECK : S_BIT_LOW;
                end else if (cnt >= TMO_M1) begin
                    fail      = 1'b1;
                    fail_code = E_BIT;
                end
            end
            S_CHECK: begin
`ifdef DHT_CRC_CHECK_EN
                if (crc_sum == shreg[7:0]) begin
                    ok_done = 1'b1;
                    nxt     = S_COOL;
                end else begin
                    fail      = 1'b1;
                    fail_code = E_CRC;
                end
`else
                ok_done = 1'b1;
                nxt     = S_COOL;
`endif
            end
            S_HOLDOFF: begin
                if (cnt == HOLD_M1) nxt = S_START_LOW;
            end
            S_COOL: begin
                if (cool_done) nxt = S_IDLE;
            end
            default: nxt = S_IDLE;
        endcase

        if (fail) nxt = (retry < RETRY_MAX) ? S_HOLDOFF : S_COOL;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state    <= S_IDLE;
            cnt      <= '0;
            ms_cnt   <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            retry    <= '0;
            mode_q   <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            ERR_CODE <= E_OK;
            HUM      <= '0;
            TEMP     <= '0;
            CRC      <= '0;
        end else begin
            state <= nxt;
            BUSY  <= (nxt != S_IDLE);
            DONE  <= 1'b0;

            if ((nxt != state) || cool_tick) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end

            if (state != S_COOL) begin
                ms_cnt <= '0;
            end else if (cool_tick) begin
                ms_cnt <= ms_cnt + 1'b1;
            end

            if (state == S_IDLE && START) begin
                mode_q <= MODE;
                retry  <= '0;
            end

            if (nxt == S_START_LOW && state != S_START_LOW) begin
                bit_idx <= '0;
            end

            if (shift_en) begin
                shreg   <= {shreg[38:0], bit_val};
                bit_idx <= bit_idx + 1'b1;
            end

            if (fail) begin
                if (retry < RETRY_MAX) begin
                    retry <= retry + 1'b1;
                end else begin
                    DONE     <= 1'b1;
                    ERR      <= 1'b1;
                    ERR_CODE <= fail_code;
                end
            end

            if (ok_done) begin
                DONE     <= 1'b1;
                ERR      <= 1'b0;
                ERR_CODE <= E_OK;
                HUM      <= shreg[39:24];
                TEMP     <= shreg[23:8];
                CRC      <= shreg[7:0];
            end
        end
    end

endmodule

// File: tb/tb_dht_reader.sv
// tb_dht_reader: self-checking bench for dht_reader with a sensor model on
// the open-drain line. 1 MHz clock so one cycle is one microsecond.
module tb_dht_reader;

    logic        CLK   = 1'b0;
    logic        RST   = 1'b0;
    logic        START = 1'b0;
    logic        MODE  = 1'b0;
    logic        bfm_low = 1'b0;
    wire         dht_line;
    logic        BUSY, DONE, ERR;
    logic [2:0]  ERR_CODE;
    logic [15:0] HUM, TEMP;
    logic [7:0]  CRC;

    pullup (dht_line);
    assign dht_line = bfm_low ? 1'b0 : 1'bz;

    always #5 CLK = ~CLK;

    dht_reader #(
        .CLK_HZ  (1_000_000),
        .RETRIES (2),
        .COOL_MS (2),
        .BIT1_US (50),
        .TMO_US  (100)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .MODE     (MODE),
        .DHT_DATA (dht_line),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ERR      (ERR),
        .ERR_CODE (ERR_CODE),
        .HUM      (HUM),
        .TEMP     (TEMP),
        .CRC      (CRC)
    );

`ifdef DHT_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Line monitor: host low pulses (line low while the model is not driving),
    // the high gap before each pulse, and DONE pulses.
    int lo_len = 0, hi_len = 0, last_pulse = 0, last_gap = 0, pulses = 0, dones = 0;
    always @(posedge CLK) begin
        if (dht_line === 1'b0 && !bfm_low) begin
            lo_len <= lo_len + 1;
            if (lo_len == 0) last_gap <= hi_len;
        end else begin
            if (lo_len != 0) begin
                last_pulse <= lo_len;
                pulses     <= pulses + 1;
                hi_len     <= 1;
            end else begin
                hi_len <= hi_len + 1;
            end
            lo_len <= 0;
        end
        if (DONE) dones <= dones + 1;
    end

    typedef struct {
        logic        mode;
        logic [39:0] frame;
        bit          thr;
        int          stuck;
        int          attempts;
        logic        err;
        logic [2:0]  code;
        logic [15:0] hum;
        logic [15:0] temp;
        logic [7:0]  crc;
        int          plen;
        int          npulse;
    } vec_t;

    vec_t vt[5];
    int   thr_hi[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_line(input logic v, input int lim, input string name);
        int k = 0;
        while (dht_line !== v && k < lim) begin
            @(negedge CLK);
            k++;
        end
        if (dht_line !== v) check(name, dht_line, v);
    endtask

    task automatic wait_idle(input int lim);
        int k = 0;
        while (BUSY && k < lim) begin
            @(negedge CLK);
            k++;
        end
        if (BUSY) check("idle_timeout", BUSY, 0);
    endtask

    task automatic wait_dones(input int d0, input int lim);
        int k = 0;
        while (dones == d0 && k < lim) begin
            @(negedge CLK);
            k++;
        end
        if (dones == d0) check("done_timeout", dones - d0, 1);
    endtask

    // One sensor reply to one host start pulse. stuck: bit held high 150 us
    // then the model goes quiet; rst_bit: return at the start of that bit.
    task automatic respond(input logic [39:0] fr, input bit thr,
                           input int stuck, input int rst_bit);
        wait_line(1'b0, 30000, "host_low_timeout");
        wait_line(1'b1, 20000, "host_release_timeout");
        tick(20);
        bfm_low = 1'b1; tick(80);
        bfm_low = 1'b0; tick(80);
        for (int b = 0; b < 40; b++) begin
            int hi;
            if (b == rst_bit) return;
            bfm_low = 1'b1; tick(50);
            bfm_low = 1'b0;
            hi = fr[39-b] ? 70 : 26;
            if (thr && b < 4) hi = thr_hi[b];
            if (b == stuck) begin
                tick(150);
                return;
            end
            tick(hi);
        end
        bfm_low = 1'b1; tick(50);
        bfm_low = 1'b0;
    endtask

    task automatic pulse_start(input logic m);
        MODE  = m;
        START = 1'b1;
        tick(1);
        START = 1'b0;
    endtask

    initial begin
        int p0, d0, k;

        thr_hi[0] = 26; thr_hi[1] = 50; thr_hi[2] = 51; thr_hi[3] = 70;

        vt[0] = '{mode:1'b0, frame:40'h350018004D, thr:1'b0, stuck:-1, attempts:1,
                  err:1'b0, code:3'd0, hum:16'h3500, temp:16'h1800, crc:8'h4D,
                  plen:18000, npulse:1};
        vt[1] = '{mode:1'b1, frame:40'h010203040A, thr:1'b0, stuck:-1, attempts:1,
                  err:1'b0, code:3'd0, hum:16'h0102, temp:16'h0304, crc:8'h0A,
                  plen:1000, npulse:1};
        vt[2] = '{mode:1'b1, frame:40'h350018004D, thr:1'b1, stuck:-1, attempts:1,
                  err:1'b0, code:3'd0, hum:16'h3500, temp:16'h1800, crc:8'h4D,
                  plen:1000, npulse:1};
        if (CRC_EN) begin
            vt[3] = '{mode:1'b1, frame:40'h350018004E, thr:1'b0, stuck:-1, attempts:3,
                      err:1'b1, code:3'd5, hum:16'h3500, temp:16'h1800, crc:8'h4D,
                      plen:1000, npulse:3};
            vt[4] = '{mode:1'b1, frame:40'h0102030400, thr:1'b0, stuck:5, attempts:3,
                      err:1'b1, code:3'd4, hum:16'h3500, temp:16'h1800, crc:8'h4D,
                      plen:1000, npulse:3};
        end else begin
            vt[3] = '{mode:1'b1, frame:40'h350018004E, thr:1'b0, stuck:-1, attempts:1,
                      err:1'b0, code:3'd0, hum:16'h3500, temp:16'h1800, crc:8'h4E,
                      plen:1000, npulse:1};
            vt[4] = '{mode:1'b1, frame:40'h0102030400, thr:1'b0, stuck:5, attempts:3,
                      err:1'b1, code:3'd4, hum:16'h3500, temp:16'h1800, crc:8'h4E,
                      plen:1000, npulse:3};
        end

        // Reset state
        tick(4);
        check("rst_busy", BUSY, 0);
        check("rst_done", DONE, 0);
        check("rst_err", ERR, 0);
        check("rst_code", ERR_CODE, 0);
        check("rst_hum", HUM, 0);
        check("rst_temp", TEMP, 0);
        check("rst_crc", CRC, 0);
        check("rst_line", dht_line, 1);
        RST = 1'b1;
        tick(3);

        // Table-driven transactions
        for (int i = 0; i < 5; i++) begin
            p0 = pulses;
            d0 = dones;
            pulse_start(vt[i].mode);
            check($sformatf("v%0d_busy", i), BUSY, 1);
            for (int a = 0; a < vt[i].attempts; a++)
                respond(vt[i].frame, vt[i].thr, vt[i].stuck, -1);
            wait_dones(d0, 30000);
            check($sformatf("v%0d_err", i), ERR, vt[i].err);
            check($sformatf("v%0d_code", i), ERR_CODE, vt[i].code);
            check($sformatf("v%0d_hum", i), HUM, vt[i].hum);
            check($sformatf("v%0d_temp", i), TEMP, vt[i].temp);
            check($sformatf("v%0d_crc", i), CRC, vt[i].crc);
            check($sformatf("v%0d_start_len", i), last_pulse, vt[i].plen);
            wait_idle(5000);
            check($sformatf("v%0d_pulses", i), pulses - p0, vt[i].npulse);
            check($sformatf("v%0d_dones", i), dones - d0, 1);
        end

        // Silent sensor: three start pulses, 100 us wait + 2000 us holdoff gaps,
        // one DONE with code 1; START during COOL is ignored.
        p0 = pulses;
        d0 = dones;
        pulse_start(1'b1);
        k = 0;
        while (!DONE && k < 20000) begin
            @(negedge CLK);
            k++;
        end
        check("silent_done_seen", DONE, 1);
        check("silent_err", ERR, 1);
        check("silent_code", ERR_CODE, 1);
        check("silent_hum_held", HUM, 16'h3500);
        check("silent_crc_held", CRC, CRC_EN ? 8'h4D : 8'h4E);
        check("silent_pulses", pulses - p0, 3);
        check("silent_gap", last_gap, 2100);
        check("silent_start_len", last_pulse, 1000);
        k = 0;
        while (BUSY && k < 5000) begin
            START = (k == 10);
            @(negedge CLK);
            k++;
        end
        START = 1'b0;
        check("cool_len", k, 2000);
        tick(300);
        check("cool_start_ignored_busy", BUSY, 0);
        check("cool_start_ignored_pulse", pulses - p0, 3);
        check("silent_dones", dones - d0, 1);

        // Reset mid-frame at bit 20
        pulse_start(1'b1);
        respond(40'h010203040A, 1'b0, -1, 20);
        RST = 1'b0;
        tick(1);
        check("midrst_busy", BUSY, 0);
        check("midrst_err", ERR, 0);
        check("midrst_code", ERR_CODE, 0);
        check("midrst_hum", HUM, 0);
        check("midrst_temp", TEMP, 0);
        check("midrst_crc", CRC, 0);
        check("midrst_line", dht_line, 1);
        RST = 1'b1;
        tick(3);

        // Reset during the host start pulse releases the line on the next edge
        pulse_start(1'b0);
        tick(100);
        check("startlow_driven", dht_line, 0);
        RST = 1'b0;
        tick(1);
        check("startlow_rst_release", dht_line, 1);
        check("startlow_rst_busy", BUSY, 0);
        RST = 1'b1;
        tick(200);
        check("startlow_rst_quiet", dht_line, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
